// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions,
// multiplier iteration count and the control FSM state type.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_ASHU = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  // Flags vector is {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam int unsigned MUL_ITERS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_mul.sv
// Iterative 16x16 shift-add multiplier (low 16 result bits), one partial
// product per cycle. Only instantiated when EXEC_MUL_EN is defined.
module exec_mul
  import exec_pkg::*;
(
  input  logic        Clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        iterate_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        done_o,
  output logic [15:0] result_o
);

  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // result_o is the accumulator after the current iteration, so the final
  // product is available combinationally on the last iteration edge.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_o = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
    done_o   = iterate_i && (cnt_q == 4'(MUL_ITERS - 1));
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (iterate_i) begin
      acc_d    = result_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = done_o ? 4'd0 : cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with registered write-back and flags.
// Define EXEC_MUL_EN to add the 16-cycle iterative MUL (opcode 12).
module exec_stage
  import exec_pkg::*;
(
  input  logic        Clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] rdest_val,
  input  logic [15:0] rsrc_val,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic [3:0]  dest_loc,
  output logic        wb_en,
  output logic [3:0]  wb_loc,
  output logic [15:0] wb_data,
  output logic [4:0]  flags
);

  logic [15:0] opA, opB, aluRes, shiftRes;
  logic signed [15:0] asrRes;
  logic [16:0] sum17, diff17;
  logic [4:0]  flagsNext;
  logic        aluWr, accept;

  logic        wbEn_q, wbEn_d;
  logic [3:0]  wbLoc_q, wbLoc_d;
  logic [15:0] wbData_q, wbData_d;
  logic [4:0]  flags_q, flags_d;

  assign opA    = rdest_val;
  assign opB    = use_imm ? imm : rsrc_val;
  assign accept = in_valid && in_ready;

  always_comb begin
    aluRes    = opB;
    aluWr     = 1'b1;
    flagsNext = flags_q;
    sum17     = {1'b0, opA} + {1'b0, opB}
              + {16'd0, (opcode == OP_ADDC) ? flags_q[FLAG_C] : 1'b0};
    diff17    = {1'b0, opA} - {1'b0, opB};
    // Arithmetic shift kept in its own signed assignment so the >>> stays signed
    asrRes    = $signed(opA) >>> opB[3:0];
    if (!opB[15])              shiftRes = opA << opB[3:0];
    else if (opcode == OP_ASHU) shiftRes = asrRes;
    else                        shiftRes = opA >> opB[3:0];
    case (opcode)
      OP_ADD, OP_ADDC: begin
        aluRes            = sum17[15:0];
        flagsNext[FLAG_C] = sum17[16];
        flagsNext[FLAG_F] = (opA[15] == opB[15]) && (sum17[15] != opA[15]);
      end
      OP_ADDU: begin
        aluRes            = sum17[15:0];
        flagsNext[FLAG_C] = sum17[16];
      end
      OP_SUB: begin
        aluRes            = diff17[15:0];
        flagsNext[FLAG_C] = diff17[16];
        flagsNext[FLAG_F] = (opA[15] != opB[15]) && (diff17[15] != opA[15]);
      end
      OP_CMP: begin
        aluWr             = 1'b0;
        flagsNext[FLAG_Z] = (opA == opB);
        flagsNext[FLAG_L] = (opB > opA);
        flagsNext[FLAG_N] = ($signed(opB) > $signed(opA));
      end
      OP_AND:            aluRes = opA & opB;
      OP_OR:             aluRes = opA | opB;
      OP_XOR:            aluRes = opA ^ opB;
      OP_MOV:            aluRes = opB;
      OP_LSH, OP_ASHU:   aluRes = shiftRes;
      OP_LUI:            aluRes = {opB[7:0], opA[7:0]};
      default:           aluWr  = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  state_e      state_q, state_d;
  logic [3:0]  mulLoc_q, mulLoc_d;
  logic        mulStart, mulDone;
  logic [15:0] mulRes;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mulLoc_q <= '0;
    end else begin
      state_q  <= state_d;
      mulLoc_q <= mulLoc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mulLoc_d = mulLoc_q;
    mulStart = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && opcode == OP_MUL) begin
        state_d  = ST_MUL;
        mulLoc_d = dest_loc;
        mulStart = 1'b1;
      end
      ST_MUL:  if (mulDone) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);

  exec_mul uMul (
    .Clk       (Clk),
    .rst       (rst),
    .start_i   (mulStart),
    .iterate_i (state_q == ST_MUL),
    .a_i       (opA),
    .b_i       (opB),
    .done_o    (mulDone),
    .result_o  (mulRes)
  );
`else
  assign in_ready = 1'b1;
`endif

  // Write-back only touches wb_loc/wb_data when a result is produced
  always_comb begin
    wbEn_d   = 1'b0;
    wbLoc_d  = wbLoc_q;
    wbData_d = wbData_q;
    flags_d  = flags_q;
    if (accept) begin
      flags_d = flagsNext;
      if (aluWr) begin
        wbEn_d   = 1'b1;
        wbLoc_d  = dest_loc;
        wbData_d = aluRes;
      end
    end
`ifdef EXEC_MUL_EN
    if (mulDone) begin
      wbEn_d   = 1'b1;
      wbLoc_d  = mulLoc_q;
      wbData_d = mulRes;
    end
`endif
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wbEn_q   <= 1'b0;
      wbLoc_q  <= '0;
      wbData_q <= '0;
      flags_q  <= '0;
    end else begin
      wbEn_q   <= wbEn_d;
      wbLoc_q  <= wbLoc_d;
      wbData_q <= wbData_d;
      flags_q  <= flags_d;
    end
  end

  assign wb_en   = wbEn_q;
  assign wb_loc  = wbLoc_q;
  assign wb_data = wbData_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage; MUL vectors run only when EXEC_MUL_EN is defined.
module tb_exec_stage;
  import exec_pkg::*;

  logic        Clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [15:0] rdest_val = '0;
  logic [15:0] rsrc_val = '0;
  logic [15:0] imm = '0;
  logic        use_imm = 1'b0;
  logic [3:0]  dest_loc = '0;
  logic        wb_en;
  logic [3:0]  wb_loc;
  logic [15:0] wb_data;
  logic [4:0]  flags;

  always #5 Clk = ~Clk;

  exec_stage dut (
    .Clk       (Clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rdest_val (rdest_val),
    .rsrc_val  (rsrc_val),
    .imm       (imm),
    .use_imm   (use_imm),
    .dest_loc  (dest_loc),
    .wb_en     (wb_en),
    .wb_loc    (wb_loc),
    .wb_data   (wb_data),
    .flags     (flags)
  );

  typedef struct packed {
    logic [3:0]  loc;
    logic [15:0] data;
    logic [4:0]  flg;
  } wbExp_t;

  wbExp_t expQ[$];
  int checks = 0;
  int errors = 0;
  int runLen = 0;
  int maxRun = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write-back strobe pops one expected entry
  always @(negedge Clk) begin : monitor
    wbExp_t e;
    if (rst && wb_en) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected wb_en: loc=%0d data=0x%0h, expected no write-back",
                 wb_loc, wb_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_loc", 32'(wb_loc), 32'(e.loc));
        checkOutput("wb_data", 32'(wb_data), 32'(e.data));
        checkOutput("wb flags", 32'(flags), 32'(e.flg));
      end
    end
    runLen = wb_en ? runLen + 1 : 0;
    if (runLen > maxRun) maxRun = runLen;
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic useImm,
                               input logic [3:0] dest, input bit expWb,
                               input logic [15:0] expData, input logic [4:0] expFlags);
    int waitCnt = 0;
    wbExp_t e;
    while (!in_ready && waitCnt < 50) begin
      @(posedge Clk); #1;
      waitCnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1 within 50 cycles");
    end
    opcode    = op;
    rdest_val = a;
    use_imm   = useImm;
    if (useImm) begin
      imm      = b;
      rsrc_val = 16'hDEAD;
    end else begin
      rsrc_val = b;
      imm      = 16'hBEEF;
    end
    dest_loc = dest;
    in_valid = 1'b1;
    if (expWb) begin
      e.loc  = dest;
      e.data = expData;
      e.flg  = expFlags;
      expQ.push_back(e);
    end
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCycles;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset wb_en", 32'(wb_en), 32'h0);
    checkOutput("reset wb_loc", 32'(wb_loc), 32'h0);
    checkOutput("reset wb_data", 32'(wb_data), 32'h0);
    checkOutput("reset flags", 32'(flags), 32'h0);
    checkOutput("reset in_ready", 32'(in_ready), 32'h1);
    rst = 1'b1;
    @(posedge Clk); #1;

    applyStimulus(OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 4'd3, 1'b1, 16'h0000, 5'h10);
    applyStimulus(OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 4'd4, 1'b1, 16'h8000, 5'h04);
    applyStimulus(OP_CMP,  16'h0005, 16'hFFFF, 1'b0, 4'd5, 1'b0, 16'h0000, 5'h00);
    checkOutput("cmp flags", 32'(flags), 32'h0C);
    checkOutput("cmp wb_en", 32'(wb_en), 32'h0);
    applyStimulus(OP_LSH,  16'h8001, 16'h8001, 1'b0, 4'd5, 1'b1, 16'h4000, 5'h0C);
    applyStimulus(OP_ASHU, 16'h8001, 16'h8001, 1'b0, 4'd6, 1'b1, 16'hC000, 5'h0C);
    applyStimulus(OP_SUB,  16'h0001, 16'h0002, 1'b0, 4'd8, 1'b1, 16'hFFFF, 5'h18);
    applyStimulus(OP_ADDC, 16'h0001, 16'h0001, 1'b0, 4'd9, 1'b1, 16'h0003, 5'h08);
    applyStimulus(OP_ADDU, 16'hFFFF, 16'h0002, 1'b1, 4'd10, 1'b1, 16'h0001, 5'h18);
    applyStimulus(OP_LUI,  16'h1234, 16'h00AB, 1'b1, 4'd11, 1'b1, 16'hAB34, 5'h18);
    applyStimulus(OP_CMP,  16'h0005, 16'h0005, 1'b0, 4'd12, 1'b0, 16'h0000, 5'h00);
    checkOutput("cmp equal flags", 32'(flags), 32'h12);
    applyStimulus(4'd13,   16'h1111, 16'h2222, 1'b0, 4'd13, 1'b0, 16'h0000, 5'h00);
    checkOutput("unknown wb_en", 32'(wb_en), 32'h0);
    checkOutput("hold wb_data", 32'(wb_data), 32'hAB34);
    checkOutput("hold wb_loc", 32'(wb_loc), 32'd11);
    checkOutput("unknown flags", 32'(flags), 32'h12);
`ifndef EXEC_MUL_EN
    applyStimulus(OP_MUL,  16'h0123, 16'h0010, 1'b0, 4'd14, 1'b0, 16'h0000, 5'h00);
    checkOutput("op12 unknown in_ready", 32'(in_ready), 32'h1);
    checkOutput("op12 unknown wb_en", 32'(wb_en), 32'h0);
`endif

    @(posedge Clk); #1;
    maxRun = 0;
    applyStimulus(OP_MOV, 16'h0000, 16'h1111, 1'b1, 4'd1, 1'b1, 16'h1111, 5'h12);
    applyStimulus(OP_MOV, 16'h0000, 16'h2222, 1'b1, 4'd2, 1'b1, 16'h2222, 5'h12);
    applyStimulus(OP_XOR, 16'h1111, 16'h2222, 1'b0, 4'd7, 1'b1, 16'h3333, 5'h12);
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("back-to-back wb_en run", 32'(maxRun), 32'd3);

`ifdef EXEC_MUL_EN
    applyStimulus(OP_MUL, 16'h0123, 16'h0010, 1'b0, 4'd12, 1'b1, 16'h1230, 5'h12);
    busyCycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (in_ready) break;
      busyCycles++;
    end
    checkOutput("mul busy cycles", 32'(busyCycles), 32'd16);
    @(posedge Clk); #1;
    checkOutput("mul wb_en one cycle", 32'(wb_en), 32'h0);

    applyStimulus(OP_MUL, 16'h0123, 16'h0010, 1'b0, 4'd13, 1'b0, 16'h0000, 5'h00);
    repeat (7) @(posedge Clk);
    #1;
    checkOutput("mul mid in_ready", 32'(in_ready), 32'h0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("abort in_ready", 32'(in_ready), 32'h1);
    checkOutput("abort wb_en", 32'(wb_en), 32'h0);
    checkOutput("abort wb_data", 32'(wb_data), 32'h0);
    checkOutput("abort wb_loc", 32'(wb_loc), 32'h0);
    checkOutput("abort flags", 32'(flags), 32'h0);
    @(posedge Clk); #1;
    rst = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'h1);
    checkOutput("post-reset wb_data", 32'(wb_data), 32'h0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, operation presented.
REQ-004 SHALL have port in_ready, output, 1, stage can accept; an operation transfers on a Clk edge where in_valid and in_ready are both 1.
REQ-005 SHALL have port opcode, input, 4, operation select.
REQ-006 SHALL have port rdest_val, input, 16, operand A (destination register value from the register file).
REQ-007 SHALL have port rsrc_val, input, 16, source register value.
REQ-008 SHALL have port imm, input, 16, immediate value.
REQ-009 SHALL have port use_imm, input, 1, operand B = imm when 1, else rsrc_val.
REQ-010 SHALL have port dest_loc, input, 4, write-back register index.
REQ-011 SHALL have port wb_en, output, 1, one-cycle write strobe to the register file.
REQ-012 SHALL have port wb_loc, output, 4, write-back register index.
REQ-013 SHALL have port wb_data, output, 16, write-back value.
REQ-014 SHALL have port flags, output, 5, {C,L,F,Z,N}; bit 4 = C, bit 0 = N.

Function
REQ-015 SHALL use these opcodes: 0 ADD, 1 ADDU, 2 ADDC, 3 SUB, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 MOV, 9 LSH, 10 ASHU, 11 LUI, 12 MUL; 13-15 are unknown.
REQ-016 SHALL compute ADD/ADDU as A+B, ADDC as A+B+C, SUB as A-B, and MOV as B.
REQ-017 SHALL compute LSH as A shifted by B[3:0]: left when B[15]=0, logical right when B[15]=1.
REQ-018 SHALL compute ASHU like LSH but with arithmetic right shift, and LUI as {B[7:0],A[7:0]}.
REQ-019 SHALL keep all results modulo 2^16.
REQ-020 SHALL update flags as follows:
- ADD, ADDC, SUB: C = carry out (SUB: borrow), F = signed overflow.
- ADDU: C only.
- CMP: Z = (A==B), L = B>A unsigned, N = B>A signed.
- All other opcodes, including MUL: flags unchanged.
REQ-021 SHALL treat single-cycle ops as latency 1: on the accept edge, wb_data, wb_loc and flags are registered, and wb_en = 1 for exactly the following cycle.
REQ-022 SHALL NOT assert wb_en for CMP or unknown opcodes; these are still accepted and consume one slot.
REQ-023 SHALL hold in_ready = 1 in state IDLE, so back-to-back single-cycle ops are accepted every cycle and wb_en stays high continuously.
REQ-024 SHALL implement FSM states IDLE and MUL:
- IDLE to MUL on accepting MUL.
- MUL to IDLE after 16 iterations.
- in_ready = 0 while in MUL.
REQ-025 SHALL, for MUL, latch A, B and dest_loc at accept, perform one shift-add iteration per cycle, and on the 16th edge after accept register the low 16 bits of A*B with wb_en = 1 for one cycle.
REQ-026 SHALL hold wb_data and wb_loc stable when wb_en = 0.

Reset
REQ-027 SHALL, while rst = 0, force wb_en = 0, wb_loc = 0, wb_data = 0, flags = 0, FSM = IDLE and the iteration counter = 0.
REQ-028 SHALL abort an in-progress MUL on reset with no write-back.
REQ-029 SHALL hold in_ready = 1 during and after reset.

Configuration
REQ-030 SHALL, with EXEC_MUL_EN defined, implement MUL per REQ-024 and REQ-025.
REQ-031 SHALL, without EXEC_MUL_EN, treat opcode 12 as unknown, omit the MUL state, and tie in_ready = 1.

Structure
REQ-032 SHALL place opcode constants, flag bit indices and the FSM state type in shared package exec_pkg.
REQ-033 SHALL implement the iterative multiplier as sub-module exec_mul, instantiated only under EXEC_MUL_EN.

Verification
REQ-034 SHALL cover: ADD A=0xFFFF, B=0x0001, dest 3 -> next cycle wb_en=1, wb_loc=3, wb_data=0x0000, C=1, F=0.
REQ-035 SHALL cover: ADD A=0x7FFF, B=0x0001 -> wb_data=0x8000, F=1, C=0.
REQ-036 SHALL cover: CMP A=0x0005, B=0xFFFF -> no wb_en, Z=0, L=1, N=0.
REQ-037 SHALL cover: LSH A=0x8001, B=0x8001 -> wb_data=0x4000; ASHU with the same operands -> wb_data=0xC000.
REQ-038 SHALL cover: MUL A=0x0123, B=0x0010 (EXEC_MUL_EN) -> in_ready=0 for 16 cycles, then wb_data=0x1230, wb_en=1 for one cycle; rst=0 asserted at cycle 8 -> no wb_en and in_ready=1.
REQ-039 SHALL cover: three back-to-back ops (MOV 0x1111→r1, MOV 0x2222→r2, XOR) -> wb_en high for three consecutive cycles with matching wb_loc and wb_data.
